// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
// Holds the FSM state enum, ceil-log2 and the rotated-priority mask.
package rr_lock_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  // Requesters strictly after the last winner get first pick.
  function automatic logic [31:0] prio_mask(
    input int n,
    input int last
  );
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i > last && i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_oh_to_index.sv
// One-hot to binary index encoder using a halving OR-fold.
// Each level's upper half gives one index bit; zero input gives 0.
module oh_to_index
  import rr_lock_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          oh,
  output logic [clog2(N)-1:0]   idx
);

  localparam int CW = clog2(N);
  localparam int P  = 1 << CW;

  logic [P-1:0] f;
  logic         hi;

  always_comb begin
    f        = '0;
    f[N-1:0] = oh;
    idx      = '0;
    hi       = 1'b0;
    for (int l = CW - 1; l >= 0; l--) begin
      hi = 1'b0;
      for (int j = 0; j < P; j++) begin
        if (j >= (1 << l) && j < (2 << l)) hi = hi | f[j];
      end
      idx[l] = hi;
      for (int j = 0; j < P / 2; j++) begin
        if (j < (1 << l)) f[j] = f[j] | f[j + (1 << l)];
      end
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter for one valid/ready channel with locked bursts.
// A winner that fires with lock held keeps the grant for BEATS fires.
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          io_in_valid,
  output logic [N-1:0]          io_in_ready,
  input  logic [N-1:0]          io_in_lock,
  input  logic [N*W-1:0]        io_in_bits,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [W-1:0]          io_out_bits,
  output logic [clog2(N)-1:0]   io_chosen,
  output logic [N-1:0]          io_chosen_oh,
  output logic                  io_locked
);

  localparam int CW = clog2(N);
  localparam int BW = clog2(BEATS);
  localparam logic [N-1:0] ONE = 1;

  state_t          state, state_n;
  logic [CW-1:0]   last, last_n;
  logic [CW-1:0]   lidx, lidx_n;
  logic [BW-1:0]   cnt, cnt_n;
  logic [N-1:0]    pmask, rot, pend, grant_oh;
  logic [CW-1:0]   g;
  logic            fire, g_lock;

  assign pmask = N'(prio_mask(N, int'(last)));

  // Prefer requesters after last; otherwise wrap to the lowest valid.
  always_comb begin
    rot      = io_in_valid & pmask;
    pend     = (|rot) ? rot : io_in_valid;
    grant_oh = '0;
    if (reset) begin
      grant_oh = '0;
    end else if (state == LOCKED) begin
      grant_oh = ONE << lidx;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend[i]) grant_oh = ONE << i;
      end
    end
  end

  oh_to_index #(.N(N)) u_enc (
    .oh  (grant_oh),
    .idx (g)
  );

  always_comb begin
    io_out_bits = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_oh[i]) io_out_bits = io_in_bits[i*W +: W];
    end
    io_out_valid = |(grant_oh & io_in_valid);
    io_in_ready  = grant_oh & {N{io_out_ready}};
    g_lock       = |(grant_oh & io_in_lock);
    fire         = io_out_valid & io_out_ready;
    io_chosen    = g;
    io_chosen_oh = grant_oh;
    io_locked    = !reset && (state == LOCKED);
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    lidx_n  = lidx;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (fire) begin
          if (g_lock) begin
            state_n = LOCKED;
            lidx_n  = g;
            cnt_n   = BW'(BEATS - 1);
          end else begin
            last_n = g;
          end
        end
      end
      LOCKED: begin
        if (fire) begin
          if (cnt > BW'(1)) begin
            cnt_n = cnt - BW'(1);
          end else begin
            state_n = IDLE;
            last_n  = lidx;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= CW'(N - 1);
      lidx  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      lidx  <= lidx_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter, N=4 and N=3 instances.
// A rule-level model predicts each cycle; a monitor pops and compares.
module tb_rr_lock_arbiter;

  localparam int BEATS = 4;

  typedef struct {
    logic       ov;
    logic [7:0] bits;
    int         chosen;
    logic [3:0] oh;
    logic [3:0] rdy;
    logic       locked;
  } exp_t;

  typedef struct {
    bit locked;
    int owner;
    int left;
    int last;
  } model_t;

  logic        clk;
  logic        rst;
  logic [3:0]  v, lk;
  logic        rdy;
  logic [31:0] bits;

  logic [3:0]  ir4, oh4;
  logic        ov4, lo4;
  logic [7:0]  ob4;
  logic [1:0]  ch4;
  logic [2:0]  ir3, oh3;
  logic        ov3, lo3;
  logic [7:0]  ob3;
  logic [1:0]  ch3;

  int checks = 0;
  int failures = 0;
  exp_t q4[$];
  exp_t q3[$];
  model_t m4, m3;

  rr_lock_arbiter #(.N(4), .W(8), .BEATS(BEATS)) u4 (
    .clk(clk), .reset(rst),
    .io_in_valid(v), .io_in_ready(ir4),
    .io_in_lock(lk), .io_in_bits(bits),
    .io_out_valid(ov4), .io_out_ready(rdy),
    .io_out_bits(ob4), .io_chosen(ch4),
    .io_chosen_oh(oh4), .io_locked(lo4)
  );

  rr_lock_arbiter #(.N(3), .W(8), .BEATS(BEATS)) u3 (
    .clk(clk), .reset(rst),
    .io_in_valid(v[2:0]), .io_in_ready(ir3),
    .io_in_lock(lk[2:0]), .io_in_bits(bits[23:0]),
    .io_out_valid(ov3), .io_out_ready(rdy),
    .io_out_bits(ob3), .io_chosen(ch3),
    .io_chosen_oh(oh3), .io_locked(lo3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: expected outputs this cycle and state after the edge.
  function automatic void mstep(
    input  int          n,
    input  model_t      m,
    output exp_t        e,
    output model_t      nm
  );
    int  g;
    bit  fire;
    e  = '{1'b0, 8'h00, 0, 4'h0, 4'h0, 1'b0};
    nm = m;
    if (rst) begin
      nm = '{1'b0, 0, 0, n - 1};
      return;
    end
    g = -1;
    if (m.locked) begin
      g = m.owner;
    end else begin
      for (int k = 1; k <= n; k++) begin
        if (g < 0 && v[(m.last + k) % n]) g = (m.last + k) % n;
      end
    end
    e.locked = m.locked;
    if (g < 0) return;
    e.oh     = 4'(1 << g);
    e.chosen = g;
    e.ov     = v[g];
    e.bits   = bits[g*8 +: 8];
    e.rdy    = rdy ? e.oh : 4'h0;
    fire     = e.ov && rdy;
    if (!fire) return;
    if (m.locked) begin
      nm.left = m.left - 1;
      if (nm.left == 0) begin
        nm.locked = 1'b0;
        nm.last   = m.owner;
      end
    end else if (lk[g]) begin
      nm.locked = 1'b1;
      nm.owner  = g;
      nm.left   = BEATS - 1;
    end else begin
      nm.last = g;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] vv,
                     input logic [3:0] ll, input logic rr);
    exp_t   e;
    model_t nm;
    @(negedge clk);
    rst  = r;
    v    = vv;
    lk   = ll;
    rdy  = rr;
    bits = $urandom;
    mstep(4, m4, e, nm);
    q4.push_back(e);
    m4 = nm;
    mstep(3, m3, e, nm);
    q3.push_back(e);
    m3 = nm;
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("n4_valid", 32'(ov4), 32'(e.ov));
      if (e.ov) chk("n4_bits", 32'(ob4), 32'(e.bits));
      chk("n4_chosen", 32'(ch4), 32'(e.chosen));
      chk("n4_oh", 32'(oh4), 32'(e.oh));
      chk("n4_ready", 32'(ir4), 32'(e.rdy));
      chk("n4_locked", 32'(lo4), 32'(e.locked));
      chk("n4_onehot0", 32'($onehot0(oh4)), 32'd1);
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("n3_valid", 32'(ov3), 32'(e.ov));
      if (e.ov) chk("n3_bits", 32'(ob3), 32'(e.bits));
      chk("n3_chosen", 32'(ch3), 32'(e.chosen));
      chk("n3_oh", 32'(oh3), 32'(e.oh[2:0]));
      chk("n3_ready", 32'(ir3), 32'(e.rdy[2:0]));
      chk("n3_locked", 32'(lo3), 32'(e.locked));
    end
  end

  initial begin
    rst  = 1'b1;
    v    = '0;
    lk   = '0;
    rdy  = 1'b0;
    bits = '0;
    m4   = '{1'b0, 0, 0, 3};
    m3   = '{1'b0, 0, 0, 2};
    cyc(1, 4'hF, 4'h0, 1);
    cyc(1, 4'hF, 4'h0, 1);
    repeat (5) cyc(0, 4'hF, 4'h0, 1);
    repeat (2) cyc(0, 4'h4, 4'h0, 1);
    cyc(0, 4'h1, 4'h0, 1);
    cyc(0, 4'hB, 4'h2, 1);
    repeat (4) cyc(0, 4'hB, 4'h0, 1);
    cyc(0, 4'h1, 4'h0, 1);
    cyc(0, 4'hB, 4'h2, 1);
    repeat (5) cyc(0, 4'hB, 4'h0, 0);
    repeat (2) cyc(0, 4'h9, 4'h0, 1);
    repeat (4) cyc(0, 4'hB, 4'h0, 1);
    cyc(0, 4'h1, 4'h0, 1);
    cyc(0, 4'hB, 4'h2, 1);
    cyc(0, 4'hB, 4'h0, 1);
    cyc(1, 4'hF, 4'h0, 1);
    repeat (2) cyc(0, 4'hF, 4'h0, 1);
    repeat (4) cyc(0, 4'h5, 4'h0, 1);
    cyc(0, 4'hF, 4'hF, 0);
    cyc(0, 4'h0, 4'h0, 1);
    repeat (3000) begin
      cyc(($urandom_range(99) == 0), 4'($urandom),
          4'($urandom) & 4'($urandom),
          ($urandom_range(9) < 7));
    end
    @(negedge clk);
    #3;
    chk("queue_drained", 32'(q4.size() + q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
